tt_host_driver: RTL
===================

# tt_host_driver

Host-side driver for a Tiny Tapeout user design: the block on the opposite end of the standard TT user-project pin interface. It accepts byte commands from a test/controller path, drives the design's dedicated inputs, bidirectional inputs, clock, reset and enable, and returns samples of the design's outputs. It sits between the on-board controller or bench and the DUT wrapper, and single-steps the DUT at a divided rate of the system clock.

## Interface

- CLK_DIV, 2: system cycles per DUT clock half-period; legal range ≥1.
- SYNC_STAGES, 2: flop stages on every DUT-to-host input; legal range ≥1.

- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when valid & ready
- cmd_op  input  2  opcode: 0 SET_UI, 1 SET_UIO, 2 STEP, 3 CTRL
- cmd_data  input  8  opcode operand
- rsp_valid  output  1  response byte available
- rsp_ready  input  1  response consumed when valid & ready
- rsp_data  output  8  response byte
- dut_ui_in  output  8  to DUT ui_in
- dut_uio_in  output  8  to DUT uio_in
- dut_uo_out  input  8  from DUT uo_out
- dut_uio_out  input  8  from DUT uio_out
- dut_uio_oe  input  8  from DUT uio_oe (1 = DUT drives the pin)
- dut_clk  output  1  DUT clock, registered
- dut_rst_n  output  1  DUT reset, active-low
- dut_ena  output  1  DUT enable

## Operation

- Reset values: dut_ui_in 0, dut_uio_in 0, dut_clk 0, dut_rst_n 0 (DUT held in reset), dut_ena 0, rsp_valid 0, rsp_data 0, cmd_ready 0 while rst is high.
- All DUT inputs pass through SYNC_STAGES flops before use.
- States: IDLE, HIGH, LOW, SETTLE, RESP.
- IDLE: cmd_ready = 1 when rsp_valid is 0. No other state asserts cmd_ready.
- SET_UI: dut_ui_in <= cmd_data. Stay in IDLE. No response.
- SET_UIO: dut_uio_in <= cmd_data. Stay in IDLE. No response.
- STEP: pulse count <= cmd_data + 1 (9-bit, so 1..256 pulses). Go to HIGH.
  - HIGH: dut_clk = 1 for CLK_DIV cycles, then go to LOW.
  - LOW: dut_clk = 0 for CLK_DIV cycles, then decrement the count. If the count is non-zero, go to HIGH; otherwise go to SETTLE.
  - SETTLE: wait SYNC_STAGES cycles, then latch synced uo_out into rsp_data and go to RESP.
- CTRL: dut_rst_n <= cmd_data[0], dut_ena <= cmd_data[1].
  - If cmd_data[2] = 1, rsp_data <= per bit (oe ? synced uio_out : dut_uio_in) and go to RESP.
  - Otherwise stay in IDLE.
  - cmd_data[7:3] are ignored.
- RESP: rsp_valid = 1 and rsp_data stable until rsp_ready. Return to IDLE in the cycle after the handshake.
- Only STEP changes dut_clk. dut_ui_in, dut_uio_in, dut_rst_n and dut_ena never change while dut_clk = 1.

## Timing

- SET_UI, SET_UIO and CTRL fields accepted at cycle N are visible on their output pins at N+1.
- STEP accepted at N:
  - dut_clk rises at N+1.
  - Each pulse is 2·CLK_DIV cycles, high phase first.
  - rsp_valid rises at N+1+2·CLK_DIV·(cmd_data+1)+SYNC_STAGES.
- CTRL read accepted at N: rsp_valid at N+1. The sampled uio_out value is the synced value present at N.
- The earliest next command acceptance is the cycle after the rsp handshake.
- When rsp_ready is held high, rsp_valid is high for exactly one cycle.
- rst asserted mid-STEP:
  - dut_clk = 0 at the next edge.
  - The remaining count and the pending response are discarded.
  - Every output takes its reset value.
- rst takes priority over a simultaneous command or response handshake.
- cmd_valid held in any non-IDLE state is not accepted and does not stall or corrupt the current operation.

## Structure

- Shared package tt_host_pkg holds the opcode constants (OP_SET_UI, OP_SET_UIO, OP_STEP, OP_CTRL), the CTRL bit positions, and the state enum.
- Sub-module tt_sync is a parameterised-width, SYNC_STAGES-deep synchronizer. It is instantiated for uo_out, uio_out and uio_oe.
- The FSM, pulse counter, phase counter and response register live in tt_host_driver.

## Test plan

- Reset, then idle 5 cycles:
  - dut_rst_n = 0, dut_ena = 0, dut_clk = 0, rsp_valid = 0 throughout.
  - cmd_ready = 1 from the first cycle after rst deasserts.
- CTRL 0x03, SET_UI 0xA5, then STEP 0x00 with a DUT model computing uo_out = ~ui_in on the dut_clk rise:
  - Exactly one pulse, 2 cycles high and 2 low.
  - rsp_data = 0x5A, rsp_valid at N+7 with defaults.
- STEP 0xFF against a counter DUT:
  - Exactly 256 dut_clk rises.
  - rsp_data = counter low byte, i.e. previous value + 0x00 mod 256 (an unchanged value for an 8-bit counter).
  - cmd_ready = 0 for the full duration.
- CTRL 0x07 with dut_uio_oe = 0xF0, dut_uio_out = 0x3C, after SET_UIO 0x99: rsp_data = 0x39.
- Hold rsp_ready low for 10 cycles after a STEP:
  - rsp_valid and rsp_data stay stable.
  - A concurrent cmd_valid is ignored.
  - Response completes on rsp_ready.
- Assert rst during the 3rd pulse of STEP 0x07:
  - dut_clk = 0 next cycle.
  - No rsp_valid.
  - All outputs return to reset values.
  - A new STEP after reset produces the correct pulse count.

Source files
------------

// File: rtl/tt_host_pkg.sv
// Shared opcodes, CTRL bit positions and FSM state encodings for the
// Tiny Tapeout host driver.
package tt_host_pkg;

  localparam logic [1:0] OP_SET_UI  = 2'd0;
  localparam logic [1:0] OP_SET_UIO = 2'd1;
  localparam logic [1:0] OP_STEP    = 2'd2;
  localparam logic [1:0] OP_CTRL    = 2'd3;

  localparam int CTRL_RST_N_BIT = 0;
  localparam int CTRL_ENA_BIT   = 1;
  localparam int CTRL_READ_BIT  = 2;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_HIGH   = 3'd1;
  localparam state_t ST_LOW    = 3'd2;
  localparam state_t ST_SETTLE = 3'd3;
  localparam state_t ST_RESP   = 3'd4;

  // A pad reads back what the DUT drives where it owns the pin, else what we drive.
  function automatic logic [7:0] uio_view(input logic [7:0] oe,
                                          input logic [7:0] dut_val,
                                          input logic [7:0] host_val);
    return (oe & dut_val) | (~oe & host_val);
  endfunction

endpackage

// File: rtl/tt_host_driver_if.sv
// Command / response byte channels between a controller and tt_host_driver.
interface tt_host_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/tt_sync.sv
// Multi-flop synchronizer for DUT-to-host signals; data only, no reset.
module tt_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p [STAGES];

  always_ff @(posedge clk) begin
    sync_p[0] <= d;
    for (int i = 1; i < STAGES; i++) begin
      sync_p[i] <= sync_p[i-1];
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/tt_host_driver.sv
// Host-side driver for a Tiny Tapeout user design: applies byte commands to the
// DUT pins, single-steps its clock at a divided rate and returns output samples.
module tt_host_driver
  import tt_host_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  tt_host_driver_if.slave      host,
  output logic [7:0]           dut_ui_in,
  output logic [7:0]           dut_uio_in,
  input  logic [7:0]           dut_uo_out,
  input  logic [7:0]           dut_uio_out,
  input  logic [7:0]           dut_uio_oe,
  output logic                 dut_clk,
  output logic                 dut_rst_n,
  output logic                 dut_ena
);

  localparam int PH_MAX = (CLK_DIV > SYNC_STAGES) ? CLK_DIV : SYNC_STAGES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] CD_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] SS_LAST = PH_W'(SYNC_STAGES - 1);

  state_t          state;
  logic [PH_W-1:0] phase;
  logic [8:0]      pulse_cnt;
  logic [7:0]      rsp_data_q;
  logic [7:0]      uo_s, uio_out_s, uio_oe_s;

  tt_sync #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync_uo  (.clk(clk), .d(dut_uo_out),  .q(uo_s));
  tt_sync #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync_uio (.clk(clk), .d(dut_uio_out), .q(uio_out_s));
  tt_sync #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync_oe  (.clk(clk), .d(dut_uio_oe),  .q(uio_oe_s));

  // Ready is masked by rst so nothing looks acceptable while reset is held.
  assign host.cmd_ready = (state == ST_IDLE) && !rst;
  assign host.rsp_valid = (state == ST_RESP);
  assign host.rsp_data  = rsp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase      <= '0;
      pulse_cnt  <= '0;
      rsp_data_q <= '0;
      dut_ui_in  <= '0;
      dut_uio_in <= '0;
      dut_clk    <= 1'b0;
      dut_rst_n  <= 1'b0;
      dut_ena    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (host.cmd_valid) begin
            case (host.cmd_op)
              OP_SET_UI:  dut_ui_in  <= host.cmd_data;
              OP_SET_UIO: dut_uio_in <= host.cmd_data;
              OP_STEP: begin
                pulse_cnt <= {1'b0, host.cmd_data} + 9'd1;
                phase     <= '0;
                dut_clk   <= 1'b1;
                state     <= ST_HIGH;
              end
              OP_CTRL: begin
                dut_rst_n <= host.cmd_data[CTRL_RST_N_BIT];
                dut_ena   <= host.cmd_data[CTRL_ENA_BIT];
                if (host.cmd_data[CTRL_READ_BIT]) begin
                  rsp_data_q <= uio_view(uio_oe_s, uio_out_s, dut_uio_in);
                  state      <= ST_RESP;
                end
              end
              default: ;
            endcase
          end
        end
        ST_HIGH: begin
          if (phase == CD_LAST) begin
            phase   <= '0;
            dut_clk <= 1'b0;
            state   <= ST_LOW;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_LOW: begin
          if (phase == CD_LAST) begin
            phase     <= '0;
            pulse_cnt <= pulse_cnt - 9'd1;
            if (pulse_cnt == 9'd1) begin
              state <= ST_SETTLE;
            end else begin
              dut_clk <= 1'b1;
              state   <= ST_HIGH;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        // Let the final edge's effect on uo_out clear the synchronizer.
        ST_SETTLE: begin
          if (phase == SS_LAST) begin
            phase      <= '0;
            rsp_data_q <= uo_s;
            state      <= ST_RESP;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_RESP: begin
          if (host.rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
